// File: rtl/sensor_acude.sv
// Water-level sensor conditioner: classifies valid samples, requires CONFIRM matching
// classifications before changing the output code, and forces the fault code after TIMEOUT idle cycles.
// Optional hysteresis around the current output code is compiled in with SENSOR_HISTERESE_EN.
module sensor_acude #(
   parameter int unsigned CONFIRM = 4,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic       clk_2,
   input  logic       reset,
   input  logic [6:0] nivel,
   input  logic       nivel_valido,
   output logic [1:0] sensor,
   output logic       mudou
);

   localparam logic [3:0]  CONFIRM_C = 4'(CONFIRM);
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   localparam logic [1:0] CLS_DEFEITO = 2'b11;
   localparam logic [1:0] CLS_BAIXO   = 2'b10;
   localparam logic [1:0] CLS_NORMAL  = 2'b01;
   localparam logic [1:0] CLS_ALTO    = 2'b00;

   typedef enum logic [1:0] {
      INIT      = 2'd0,
      ESTAVEL   = 2'd1,
      CANDIDATO = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sensor_q, sensor_d;
   logic        mudou_q, mudou_d;
   logic [1:0]  cand_q, cand_d;
   logic [3:0]  count_q, count_d;
   logic [15:0] idle_q, idle_d;

   logic [1:0]  sampleClass;
   logic        trackCand;
   logic [1:0]  candVal;
   logic [3:0]  candCnt;

   function automatic logic [1:0] classify(input logic [6:0] value);
      logic [1:0] cls;
      if (value > 7'd100)
         cls = CLS_DEFEITO;
      else if (value <= 7'd30)
         cls = CLS_BAIXO;
      else if (value <= 7'd80)
         cls = CLS_NORMAL;
      else
         cls = CLS_ALTO;
      return cls;
   endfunction

`ifdef SENSOR_HISTERESE_EN
   // Widened bands around the current code; a sample inside the band keeps the current class.
   function automatic logic [1:0] applyHysteresis(input logic [6:0] value,
                                                  input logic [1:0] baseCls,
                                                  input logic [1:0] current);
      logic [1:0] cls;
      cls = baseCls;
      if (baseCls != CLS_DEFEITO) begin
         case (current)
            CLS_NORMAL: begin
               if (baseCls == CLS_BAIXO && value > 7'd28)
                  cls = CLS_NORMAL;
               else if (baseCls == CLS_ALTO && value < 7'd83)
                  cls = CLS_NORMAL;
            end
            CLS_BAIXO: begin
               if (baseCls == CLS_NORMAL && value < 7'd33)
                  cls = CLS_BAIXO;
            end
            CLS_ALTO: begin
               if (baseCls == CLS_NORMAL && value > 7'd78)
                  cls = CLS_ALTO;
            end
            default: cls = baseCls;
         endcase
      end
      return cls;
   endfunction
`endif

   always_comb begin
      sampleClass = classify(nivel);
`ifdef SENSOR_HISTERESE_EN
      if (state_q != INIT)
         sampleClass = applyHysteresis(nivel, classify(nivel), sensor_q);
`endif
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state_q  <= INIT;
         sensor_q <= CLS_DEFEITO;
         mudou_q  <= 1'b0;
         cand_q   <= 2'b00;
         count_q  <= 4'd0;
         idle_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         sensor_q <= sensor_d;
         mudou_q  <= mudou_d;
         cand_q   <= cand_d;
         count_q  <= count_d;
         idle_q   <= idle_d;
      end
   end

   // Each state only decides which candidate/count a valid sample produces; the commit
   // check is shared so CONFIRM = 1 commits straight from INIT or ESTAVEL.
   always_comb begin
      state_d   = state_q;
      sensor_d  = sensor_q;
      mudou_d   = 1'b0;
      cand_d    = cand_q;
      count_d   = count_q;
      idle_d    = idle_q;
      trackCand = 1'b0;
      candVal   = cand_q;
      candCnt   = count_q;

      if (nivel_valido) begin
         idle_d = 16'd0;
         case (state_q)
            INIT: begin
               trackCand = 1'b1;
               candVal   = sampleClass;
               candCnt   = 4'd1;
            end
            ESTAVEL: begin
               if (sampleClass != sensor_q) begin
                  trackCand = 1'b1;
                  candVal   = sampleClass;
                  candCnt   = 4'd1;
               end
            end
            CANDIDATO: begin
               if (sampleClass == cand_q) begin
                  trackCand = 1'b1;
                  candVal   = cand_q;
                  candCnt   = count_q + 4'd1;
               end else if (sampleClass == sensor_q) begin
                  state_d = ESTAVEL;
                  count_d = 4'd0;
               end else begin
                  trackCand = 1'b1;
                  candVal   = sampleClass;
                  candCnt   = 4'd1;
               end
            end
            default: begin
               state_d = INIT;
               count_d = 4'd0;
            end
         endcase

         if (trackCand) begin
            cand_d = candVal;
            if (candCnt >= CONFIRM_C) begin
               sensor_d = candVal;
               mudou_d  = (candVal != sensor_q);
               state_d  = ESTAVEL;
               count_d  = 4'd0;
            end else begin
               state_d = CANDIDATO;
               count_d = candCnt;
            end
         end
      end else begin
         idle_d = (idle_q >= TIMEOUT_C) ? TIMEOUT_C : idle_q + 16'd1;
         if (idle_d == TIMEOUT_C) begin
            sensor_d = CLS_DEFEITO;
            mudou_d  = (sensor_q != CLS_DEFEITO);
            state_d  = INIT;
            cand_d   = 2'b00;
            count_d  = 4'd0;
         end
      end
   end

   assign sensor = sensor_q;
   assign mudou  = mudou_q;

endmodule

// File: tb/tb_sensor_acude.sv
// Directed bench for sensor_acude: one instance with CONFIRM = 4 and one with CONFIRM = 1,
// both with TIMEOUT = 10, driven by the same inputs.
module tb_sensor_acude;

   logic       clk_2;
   logic       reset;
   logic [6:0] nivel;
   logic       nivel_valido;
   logic [1:0] sensor;
   logic       mudou;
   logic [1:0] sensor1;
   logic       mudou1;

   int compared;
   int mismatched;

   sensor_acude #(.CONFIRM(4), .TIMEOUT(10)) dut (
      .clk_2        (clk_2),
      .reset        (reset),
      .nivel        (nivel),
      .nivel_valido (nivel_valido),
      .sensor       (sensor),
      .mudou        (mudou)
   );

   sensor_acude #(.CONFIRM(1), .TIMEOUT(10)) dut1 (
      .clk_2        (clk_2),
      .reset        (reset),
      .nivel        (nivel),
      .nivel_valido (nivel_valido),
      .sensor       (sensor1),
      .mudou        (mudou1)
   );

   initial begin
      clk_2 = 1'b0;
      forever #5 clk_2 = ~clk_2;
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs and returns 1 time unit after the sampling edge.
   task automatic applyStimulus(input logic valid, input logic [6:0] value);
      nivel_valido = valid;
      nivel        = value;
      @(posedge clk_2);
      #1;
   endtask

   task automatic applyBurst(input logic [6:0] value, input int times);
      for (int i = 0; i < times; i++)
         applyStimulus(1'b1, value);
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      reset        = 1'b1;
      nivel_valido = 1'b1;
      nivel        = 7'd50;
      repeat (2) @(posedge clk_2);
      #1;
      checkOutput("reset_sensor", 8'(sensor), 8'h3);
      checkOutput("reset_mudou", 8'(mudou), 8'h0);
      checkOutput("reset_sensor1", 8'(sensor1), 8'h3);
      reset = 1'b0;

      // Four samples of 50 from reset
      applyStimulus(1'b1, 7'd50);
      checkOutput("s50_1_sensor", 8'(sensor), 8'h3);
      checkOutput("c1_first_sensor", 8'(sensor1), 8'h1);
      checkOutput("c1_first_mudou", 8'(mudou1), 8'h1);
      applyBurst(7'd50, 2);
      checkOutput("s50_3_sensor", 8'(sensor), 8'h3);
      checkOutput("s50_3_mudou", 8'(mudou), 8'h0);
      applyStimulus(1'b1, 7'd50);
      checkOutput("s50_4_sensor", 8'(sensor), 8'h1);
      checkOutput("s50_4_mudou", 8'(mudou), 8'h1);
      applyStimulus(1'b1, 7'd50);
      checkOutput("s50_5_mudou", 8'(mudou), 8'h0);
      checkOutput("s50_5_sensor", 8'(sensor), 8'h1);

      // Candidate dropped by a sample matching the output; idle cycle changes nothing
      applyStimulus(1'b1, 7'd20);
      checkOutput("c1_20_sensor", 8'(sensor1), 8'h2);
      applyStimulus(1'b1, 7'd20);
      applyStimulus(1'b0, 7'd5);
      checkOutput("drop_idle_sensor", 8'(sensor), 8'h1);
      applyStimulus(1'b1, 7'd50);
      checkOutput("c1_50_sensor", 8'(sensor1), 8'h1);
      checkOutput("c1_50_mudou", 8'(mudou1), 8'h1);
      applyBurst(7'd20, 3);
      checkOutput("drop_6_sensor", 8'(sensor), 8'h1);
      applyStimulus(1'b1, 7'd20);
      checkOutput("drop_7_sensor", 8'(sensor), 8'h2);
      checkOutput("drop_7_mudou", 8'(mudou), 8'h1);
      checkOutput("c1_7_mudou", 8'(mudou1), 8'h0);

      // Reach alto, then fault, then back to alto
      applyBurst(7'd90, 4);
      checkOutput("alto_sensor", 8'(sensor), 8'h0);
      applyBurst(7'd120, 3);
      checkOutput("fault_3_sensor", 8'(sensor), 8'h0);
      applyStimulus(1'b1, 7'd120);
      checkOutput("fault_4_sensor", 8'(sensor), 8'h3);
      checkOutput("fault_4_mudou", 8'(mudou), 8'h1);
      applyBurst(7'd90, 4);
      checkOutput("realto_sensor", 8'(sensor), 8'h0);

      // Threshold boundaries through the CONFIRM = 1 instance
      applyStimulus(1'b1, 7'd30);
      checkOutput("b30", 8'(sensor1), 8'h2);
      applyStimulus(1'b1, 7'd31);
      checkOutput("b31", 8'(sensor1), 8'h1);
      applyStimulus(1'b1, 7'd80);
      checkOutput("b80", 8'(sensor1), 8'h1);
      applyStimulus(1'b1, 7'd81);
      checkOutput("b81", 8'(sensor1), 8'h0);
      applyStimulus(1'b1, 7'd100);
      checkOutput("b100", 8'(sensor1), 8'h0);
      applyStimulus(1'b1, 7'd101);
      checkOutput("b101", 8'(sensor1), 8'h3);
      applyStimulus(1'b1, 7'd0);
      checkOutput("b0", 8'(sensor1), 8'h2);
      applyStimulus(1'b1, 7'd127);
      checkOutput("b127", 8'(sensor1), 8'h3);
      checkOutput("mixed_hold_sensor", 8'(sensor), 8'h0);

      applyBurst(7'd50, 4);
      checkOutput("normal_again", 8'(sensor), 8'h1);
`ifdef SENSOR_HISTERESE_EN
      applyBurst(7'd29, 4);
      checkOutput("hyst_29_sensor", 8'(sensor), 8'h1);
      checkOutput("hyst_29_mudou", 8'(mudou), 8'h0);
      applyBurst(7'd28, 4);
      checkOutput("hyst_28_sensor", 8'(sensor), 8'h2);
      checkOutput("hyst_28_mudou", 8'(mudou), 8'h1);
      applyBurst(7'd32, 4);
      checkOutput("hyst_32_sensor", 8'(sensor), 8'h2);
      applyBurst(7'd50, 4);
      checkOutput("hyst_50_sensor", 8'(sensor), 8'h1);
`else
      applyBurst(7'd29, 3);
      checkOutput("fix_29_3_sensor", 8'(sensor), 8'h1);
      applyStimulus(1'b1, 7'd29);
      checkOutput("fix_29_4_sensor", 8'(sensor), 8'h2);
      checkOutput("fix_29_4_mudou", 8'(mudou), 8'h1);
      applyBurst(7'd32, 4);
      checkOutput("fix_32_sensor", 8'(sensor), 8'h1);
      applyBurst(7'd50, 4);
      checkOutput("fix_50_sensor", 8'(sensor), 8'h1);
      checkOutput("fix_50_mudou", 8'(mudou), 8'h0);
`endif

      // Timeout: a sample in the firing cycle wins, ten idle cycles force the fault code
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b0, 7'd50);
      checkOutput("idle9_sensor", 8'(sensor), 8'h1);
      applyStimulus(1'b1, 7'd50);
      checkOutput("idle10_sample_sensor", 8'(sensor), 8'h1);
      checkOutput("idle10_sample_mudou", 8'(mudou), 8'h0);
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b0, 7'd50);
      checkOutput("timeout9_sensor", 8'(sensor), 8'h1);
      applyStimulus(1'b0, 7'd50);
      checkOutput("timeout_sensor", 8'(sensor), 8'h3);
      checkOutput("timeout_mudou", 8'(mudou), 8'h1);
      checkOutput("timeout_mudou1", 8'(mudou1), 8'h1);
      applyStimulus(1'b0, 7'd50);
      checkOutput("timeout_sat_mudou", 8'(mudou), 8'h0);
      checkOutput("timeout_sat_sensor", 8'(sensor), 8'h3);

      // Commit equal to the current code must not pulse
      applyStimulus(1'b1, 7'd120);
      checkOutput("c1_same_mudou", 8'(mudou1), 8'h0);
      applyBurst(7'd120, 3);
      checkOutput("same_commit_sensor", 8'(sensor), 8'h3);
      checkOutput("same_commit_mudou", 8'(mudou), 8'h0);
      applyBurst(7'd50, 4);
      checkOutput("after_same_sensor", 8'(sensor), 8'h1);
      checkOutput("after_same_mudou", 8'(mudou), 8'h1);

      // Reset in the middle of a confirmation run
      applyBurst(7'd20, 3);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_sensor", 8'(sensor), 8'h3);
      checkOutput("midreset_mudou", 8'(mudou), 8'h0);
      nivel_valido = 1'b1;
      nivel        = 7'd20;
      repeat (2) @(posedge clk_2);
      #1;
      checkOutput("inreset_sensor", 8'(sensor), 8'h3);
      reset = 1'b0;
      applyBurst(7'd20, 3);
      checkOutput("fresh_3_sensor", 8'(sensor), 8'h3);
      applyStimulus(1'b1, 7'd20);
      checkOutput("fresh_4_sensor", 8'(sensor), 8'h2);
      checkOutput("fresh_4_mudou", 8'(mudou), 8'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sensor_acude.md
SENSOR_ACUDE -- requirements
Module: sensor_acude

Interface
- REQ-001 SHALL have parameter CONFIRM, default 4: consecutive identical classifications required before the output code changes; legal range 1..15.
- REQ-002 SHALL have parameter TIMEOUT, default 1000: clk_2 cycles without a valid sample before the fault code is forced; legal range 2..65535.
- REQ-003 SHALL have port clk_2, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port nivel, input, 7 bits: measured water volume in percent (unsigned).
- REQ-006 SHALL have port nivel_valido, input, 1 bit: nivel is sampled in cycles where this is 1.
- REQ-007 SHALL have port sensor, output, 2 bits: 11 = defeito, 10 = baixo, 01 = normal, 00 = alto; registered.
- REQ-008 SHALL have port mudou, output, 1 bit: one-cycle pulse in the cycle sensor takes a new value.

Function
- REQ-009 SHALL classify each valid sample as follows: nivel > 100 -> 11; nivel <= 30 -> 10; 31..80 -> 01; 81..100 -> 00.
- REQ-010 SHALL implement the FSM states INIT, ESTAVEL and CANDIDATO; sensor holds its value in all states except on a commit or a timeout.
- REQ-011 In INIT, SHALL load the first valid sample's class as candidate with count 1, then go to CANDIDATO; sensor stays 11.
- REQ-012 In ESTAVEL, a valid sample equal to sensor SHALL leave the state unchanged; a differing class SHALL become the candidate with count 1 and move to CANDIDATO.
- REQ-013 In CANDIDATO, a valid sample equal to the candidate SHALL increment the count; a sample equal to sensor SHALL drop the candidate and return to ESTAVEL; any other class SHALL replace the candidate with count 1.
- REQ-014 When the count reaches CONFIRM, SHALL commit: sensor = candidate on the next edge, mudou = 1 for that single cycle, and the FSM goes to ESTAVEL.
- REQ-015 With CONFIRM = 1, SHALL commit on the edge that samples the first differing class, with no residence in CANDIDATO.
- REQ-016 A commit whose value equals the current sensor SHALL NOT pulse mudou.
- REQ-017 SHALL keep an idle counter that is cleared on every valid sample and saturates at TIMEOUT.
- REQ-018 When the idle counter reaches TIMEOUT, SHALL force sensor = 11, pulse mudou if sensor was not already 11, and go to INIT.
- REQ-019 If a valid sample arrives in the same cycle the timeout would fire, the sample SHALL take priority and the timeout SHALL NOT fire.
- REQ-020 Cycles with nivel_valido = 0 SHALL NOT change the candidate or the count.
- REQ-021 The count SHALL be 4 bits wide and SHALL never exceed CONFIRM.

Reset
- REQ-022 Asserting reset SHALL immediately force sensor = 11, mudou = 0, FSM = INIT, and the count, candidate and idle counter to 0, including mid-confirmation.
- REQ-023 Samples presented while reset is high SHALL be ignored; the first edge after deassertion SHALL process inputs normally.

Configuration
- REQ-024 Macro SENSOR_HISTERESE_EN, when defined, SHALL compile in hysteresis that applies only in ESTAVEL and CANDIDATO, relative to the current sensor value:
  - sensor = 01: a sample SHALL classify as 10 only if nivel <= 28, and as 00 only if nivel >= 83;
  - sensor = 10: a sample SHALL classify as 01 only if nivel >= 33;
  - sensor = 00: a sample SHALL classify as 01 only if nivel <= 78;
  - otherwise the sample SHALL keep the sensor class; the fault rule (nivel > 100) is unaffected.
- REQ-025 Without SENSOR_HISTERESE_EN, SHALL use only the fixed thresholds of REQ-009, and no hysteresis logic SHALL be present.

Verification
- REQ-026 Reset, then 4 consecutive valid samples of nivel = 50 -> sensor 11 through the 4th sampling edge, 01 after it, with mudou high for exactly 1 cycle.
- REQ-027 From sensor = 01, send samples 20, 20, 50, 20, 20, 20, 20 -> the candidate is dropped at the 50; sensor becomes 10 only after the 7th sample.
- REQ-028 From sensor = 00, send 4 samples of nivel = 120 -> sensor = 11, mudou pulses; then 4 samples of 90 -> sensor = 00.
- REQ-029 With TIMEOUT = 10, stop valid samples while sensor = 01 -> sensor = 11 after 10 idle cycles; a sample presented exactly at cycle 10 keeps sensor = 01.
- REQ-030 With SENSOR_HISTERESE_EN and sensor = 01, 4 samples of 29 -> sensor stays 01; 4 samples of 28 -> sensor = 10; then 4 samples of 32 -> stays 10.
- REQ-031 Assert reset after the 3rd of 4 matching samples -> sensor = 11 immediately; after release, a fresh run of 4 samples is needed to commit.
